// File: rtl/valu_sequencer.sv
// Per-lane ALU sequencer: pops operand words, drives the combinational valu, buffers
// results in a small FIFO and issues VRF write-backs plus a completion pulse.

package valu_sequencer_pkg;
    typedef enum logic [2:0] {
        VADD   = 3'd0,
        VSUB   = 3'd1,
        VAND   = 3'd2,
        VOR    = 3'd3,
        VXOR   = 3'd4,
        VMERGE = 3'd5
    } vop_e;

    typedef enum logic [1:0] {
        EW8  = 2'd0,
        EW16 = 2'd1,
        EW32 = 2'd2,
        EW64 = 2'd3
    } vew_e;

    typedef logic [63:0] vrf_data_t;
endpackage

// state | meaning
// IDLE  | waiting for an instruction, insn_ready_o high
// EXEC  | firing one operand pair per cycle into the result FIFO
// DRAIN | all words fired; waiting for FIFO empty, then one-cycle done pulse
module valu_sequencer
    import valu_sequencer_pkg::*;
#(
    parameter int CntWidth     = 8,
    parameter int VrfAddrWidth = 5,
    parameter int IdWidth      = 3,
    parameter int ResBufDepth  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    insn_valid_i,
    output logic                    insn_ready_o,
    input  vop_e                    insn_op_i,
    input  vew_e                    insn_vew_i,
    input  logic [VrfAddrWidth-1:0] insn_vd_i,
    input  logic [CntWidth-1:0]     insn_words_i,
    input  logic [IdWidth-1:0]      insn_id_i,
    input  logic [1:0]              opnd_valid_i,
    output logic [1:0]              opnd_ready_o,
    input  vrf_data_t               opnd_data_i [2],
    output vrf_data_t               valu_operand_o [2],
    output vew_e                    valu_vew_o,
    output vop_e                    valu_op_o,
    input  vrf_data_t               valu_result_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [VrfAddrWidth-1:0] wb_addr_o,
    output vrf_data_t               wb_data_o,
    output logic                    done_valid_o,
    output logic [IdWidth-1:0]      done_id_o
);

    localparam int PtrW    = (ResBufDepth > 1) ? $clog2(ResBufDepth) : 1;
    localparam int CntBits = PtrW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    vop_e                    op_q;
    vew_e                    vew_q;
    logic [VrfAddrWidth-1:0] addr_q;
    logic [CntWidth-1:0]     rem_q;
    logic [IdWidth-1:0]      id_q;
    logic                    done_q, done_d;

    logic [VrfAddrWidth-1:0] fifo_addr [ResBufDepth];
    vrf_data_t               fifo_data [ResBufDepth];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0]      cnt_q;

    logic fifo_empty, fifo_full;
    logic need_vs2, opnd_ok, accept, fire, pop;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CntBits'(ResBufDepth));

    assign need_vs2 = (op_q != VMERGE);
    assign opnd_ok  = opnd_valid_i[0] & (opnd_valid_i[1] | ~need_vs2);
    assign fire     = (state_q == S_EXEC) & opnd_ok & ~fifo_full;
    assign pop      = ~fifo_empty & wb_ready_i;

    assign insn_ready_o = (state_q == S_IDLE);
    assign accept       = insn_valid_i & insn_ready_o;
    assign opnd_ready_o = {fire & need_vs2, fire};

    assign valu_operand_o[0] = opnd_data_i[0];
    assign valu_operand_o[1] = opnd_data_i[1];
    assign valu_op_o         = op_q;
    assign valu_vew_o        = vew_q;

    assign wb_valid_o   = ~fifo_empty;
    assign wb_addr_o    = fifo_addr[rd_ptr_q];
    assign wb_data_o    = fifo_data[rd_ptr_q];
    assign done_valid_o = done_q;
    assign done_id_o    = id_q;

    // The done pulse is registered and DRAIN is held through it, so the next
    // instruction is only accepted in the cycle after the pulse.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (insn_words_i == '0) ? S_DRAIN : S_EXEC;
                end
            end
            S_EXEC: begin
                if (fire && rem_q == CntWidth'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (fifo_empty) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            op_q    <= VADD;
            vew_q   <= EW8;
            addr_q  <= '0;
            rem_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                op_q   <= insn_op_i;
                vew_q  <= insn_vew_i;
                addr_q <= insn_vd_i;
                rem_q  <= insn_words_i;
                id_q   <= insn_id_i;
            end else if (fire) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (fire) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(ResBufDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(ResBufDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({fire, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted in cnt_q.
    always_ff @(posedge clk_i) begin
        if (fire) begin
            fifo_addr[wr_ptr_q] <= addr_q;
            fifo_data[wr_ptr_q] <= valu_result_i;
        end
    end

endmodule

// File: tb/tb_valu_sequencer.sv
// Directed bench for valu_sequencer with a behavioural valu model in the loop.

module tb_valu_sequencer;
    import valu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       insn_valid;
    logic       insn_ready;
    vop_e       insn_op;
    vew_e       insn_vew;
    logic [4:0] insn_vd;
    logic [7:0] insn_words;
    logic [2:0] insn_id;
    logic [1:0] opnd_valid;
    logic [1:0] opnd_ready;
    vrf_data_t  opnd_data [2];
    vrf_data_t  valu_operand [2];
    vew_e       valu_vew;
    vop_e       valu_op;
    vrf_data_t  valu_result;
    logic       wb_valid;
    logic       wb_ready;
    logic [4:0] wb_addr;
    vrf_data_t  wb_data;
    logic       done_valid;
    logic [2:0] done_id;

    int checks = 0;
    int errors = 0;

    valu_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .insn_valid_i   (insn_valid),
        .insn_ready_o   (insn_ready),
        .insn_op_i      (insn_op),
        .insn_vew_i     (insn_vew),
        .insn_vd_i      (insn_vd),
        .insn_words_i   (insn_words),
        .insn_id_i      (insn_id),
        .opnd_valid_i   (opnd_valid),
        .opnd_ready_o   (opnd_ready),
        .opnd_data_i    (opnd_data),
        .valu_operand_o (valu_operand),
        .valu_vew_o     (valu_vew),
        .valu_op_o      (valu_op),
        .valu_result_i  (valu_result),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_addr_o      (wb_addr),
        .wb_data_o      (wb_data),
        .done_valid_o   (done_valid),
        .done_id_o      (done_id)
    );

    always #5 clk = ~clk;

    function automatic vrf_data_t valu_f(vop_e op, vew_e ew, vrf_data_t a, vrf_data_t b);
        vrf_data_t r;
        r = '0;
        case (op)
            VMERGE: r = a;
            VAND:   r = a & b;
            VOR:    r = a | b;
            VXOR:   r = a ^ b;
            default: begin
                if (ew == EW8)
                    for (int i = 0; i < 8; i++)
                        r[i*8 +: 8] = (op == VSUB) ? a[i*8 +: 8] - b[i*8 +: 8] : a[i*8 +: 8] + b[i*8 +: 8];
                if (ew == EW16)
                    for (int i = 0; i < 4; i++)
                        r[i*16 +: 16] = (op == VSUB) ? a[i*16 +: 16] - b[i*16 +: 16] : a[i*16 +: 16] + b[i*16 +: 16];
                if (ew == EW32)
                    for (int i = 0; i < 2; i++)
                        r[i*32 +: 32] = (op == VSUB) ? a[i*32 +: 32] - b[i*32 +: 32] : a[i*32 +: 32] + b[i*32 +: 32];
                if (ew == EW64)
                    r = (op == VSUB) ? a - b : a + b;
            end
        endcase
        return r;
    endfunction

    always_comb valu_result = valu_f(valu_op, valu_vew, valu_operand[0], valu_operand[1]);

    // Event log, sampled mid-cycle on the falling edge.
    int         cyc_n = 0;
    int         acc_cyc;
    int         done_cnt, done_cyc, pop0, pop1;
    logic [2:0] done_id_seen;
    logic [4:0] wb_addr_log [$];
    vrf_data_t  wb_data_log [$];
    int         wb_cyc_log [$];

    always @(negedge clk) begin
        cyc_n++;
        if (rst_n) begin
            if (wb_valid && wb_ready) begin
                wb_addr_log.push_back(wb_addr);
                wb_data_log.push_back(wb_data);
                wb_cyc_log.push_back(cyc_n);
            end
            if (done_valid) begin
                done_cnt++;
                done_id_seen = done_id;
                done_cyc = cyc_n;
            end
            if (opnd_ready[0]) pop0++;
            if (opnd_ready[1]) pop1++;
            if (insn_valid && insn_ready) acc_cyc = cyc_n;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        wb_addr_log.delete();
        wb_data_log.delete();
        wb_cyc_log.delete();
        done_cnt = 0;
        done_cyc = -1;
        pop0 = 0;
        pop1 = 0;
        acc_cyc = -1;
        done_id_seen = '0;
    endtask

    task automatic issue(input vop_e op, input vew_e ew, input logic [4:0] vd,
                         input logic [7:0] words, input logic [2:0] id);
        int n = 0;
        cyc();
        insn_valid = 1'b1;
        insn_op = op;
        insn_vew = ew;
        insn_vd = vd;
        insn_words = words;
        insn_id = id;
        #1;
        while (!insn_ready && n < 50) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL issue_accept: insn_ready stayed %b, required 1", insn_ready);
        end
        cyc();
        insn_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            cyc();
            n++;
        end
        repeat (4) cyc();
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_reset();
        #1;
        checks += 4;
        if (insn_ready !== 1'b1) begin errors++; $display("FAIL rst_insn_ready: got %b required 1", insn_ready); end
        if (opnd_ready !== 2'b00) begin errors++; $display("FAIL rst_opnd_ready: got %b required 00", opnd_ready); end
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b required 0", wb_valid); end
        if (done_valid !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done_valid); end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (insn_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_idle: ready=%b wb_valid=%b required 1/0", insn_ready, wb_valid);
        end
    endtask

    task automatic test_vadd();
        clear_log();
        wb_ready = 1'b1;
        opnd_valid = 2'b11;
        opnd_data[0] = 64'h0000_0010_FFFF_FFFF;
        opnd_data[1] = 64'h0000_0001_0000_0001;
        issue(VADD, EW32, 5'd4, 8'd3, 3'd5);
        #1;
        checks++;
        if (insn_ready !== 1'b0) begin errors++; $display("FAIL vadd_busy: insn_ready=%b required 0", insn_ready); end
        wait_done(30);
        checks++;
        if (wb_addr_log.size() !== 3) begin
            errors++;
            $display("FAIL vadd_writes: got %0d required 3", wb_addr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wb_addr_log[i] !== 5'(4 + i) || wb_data_log[i] !== 64'h0000_0011_0000_0000
                    || wb_cyc_log[i] !== acc_cyc + 2 + i) begin
                    errors++;
                    $display("FAIL vadd_wb%0d: addr=%0d data=%h cyc=%0d required addr=%0d data=0000001100000000 cyc=%0d",
                             i, wb_addr_log[i], wb_data_log[i], wb_cyc_log[i], 4 + i, acc_cyc + 2 + i);
                end
            end
        end
        checks += 2;
        if (done_id_seen !== 3'd5 || done_cyc !== acc_cyc + 6) begin
            errors++;
            $display("FAIL vadd_done: id=%0d cyc=%0d required id=5 cyc=%0d", done_id_seen, done_cyc, acc_cyc + 6);
        end
        if (pop0 !== 3 || pop1 !== 3) begin
            errors++;
            $display("FAIL vadd_pops: pop0=%0d pop1=%0d required 3/3", pop0, pop1);
        end
    endtask

    task automatic test_vsub();
        clear_log();
        opnd_data[0] = 64'h0102_0304_0506_0708;
        opnd_data[1] = 64'h0101_0101_0101_0101;
        issue(VSUB, EW8, 5'd10, 8'd1, 3'd2);
        wait_done(30);
        checks += 2;
        if (wb_addr_log.size() !== 1 || wb_addr_log[0] !== 5'd10 || wb_data_log[0] !== 64'h0001_0203_0405_0607) begin
            errors++;
            $display("FAIL vsub_wb: n=%0d required 1 addr=10 data=0001020304050607", wb_addr_log.size());
        end
        if (done_id_seen !== 3'd2 || done_cyc !== acc_cyc + 4) begin
            errors++;
            $display("FAIL vsub_done: id=%0d cyc=%0d required id=2 cyc=%0d", done_id_seen, done_cyc, acc_cyc + 4);
        end
    endtask

    task automatic test_vmerge();
        clear_log();
        opnd_valid = 2'b01;
        opnd_data[0] = 64'hDEAD_BEEF_1234_5678;
        opnd_data[1] = 64'h0;
        issue(VMERGE, EW64, 5'd7, 8'd2, 3'd3);
        wait_done(30);
        checks += 3;
        if (pop1 !== 0 || pop0 !== 2) begin
            errors++;
            $display("FAIL vmerge_pops: pop0=%0d pop1=%0d required 2/0", pop0, pop1);
        end
        if (wb_addr_log.size() !== 2 || wb_addr_log[0] !== 5'd7 || wb_addr_log[1] !== 5'd8
            || wb_data_log[1] !== 64'hDEAD_BEEF_1234_5678) begin
            errors++;
            $display("FAIL vmerge_wb: n=%0d required 2 writes to 7,8 of DEADBEEF12345678", wb_addr_log.size());
        end
        if (done_id_seen !== 3'd3) begin
            errors++;
            $display("FAIL vmerge_done_id: got %0d required 3", done_id_seen);
        end
        opnd_valid = 2'b11;
    endtask

    task automatic test_back_to_back_stall();
        clear_log();
        wb_ready = 1'b0;
        opnd_data[0] = 64'd40;
        opnd_data[1] = 64'd2;
        issue(VADD, EW64, 5'd12, 8'd4, 3'd6);
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            checks++;
            if (wb_valid !== 1'b1 || wb_addr !== 5'd12 || wb_data !== 64'd42) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b addr=%0d data=%h required 1/12/2a", i, wb_valid, wb_addr, wb_data);
            end
        end
        checks++;
        if (pop0 !== 2) begin errors++; $display("FAIL stall_fires: got %0d required 2", pop0); end
        wb_ready = 1'b1;
        wait_done(40);
        checks++;
        if (wb_addr_log.size() !== 4) begin
            errors++;
            $display("FAIL stall_writes: got %0d required 4", wb_addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wb_addr_log[i] !== 5'(12 + i)) begin
                    errors++;
                    $display("FAIL stall_order%0d: addr=%0d required %0d", i, wb_addr_log[i], 12 + i);
                end
            end
        end
    endtask

    task automatic test_zero_words();
        clear_log();
        issue(VADD, EW64, 5'd3, 8'd0, 3'd6);
        wait_done(20);
        checks += 2;
        if (wb_addr_log.size() !== 0 || pop0 !== 0 || pop1 !== 0) begin
            errors++;
            $display("FAIL zero_activity: writes=%0d pop0=%0d pop1=%0d required 0", wb_addr_log.size(), pop0, pop1);
        end
        if (done_cyc !== acc_cyc + 2 || done_id_seen !== 3'd6) begin
            errors++;
            $display("FAIL zero_done: cyc=%0d id=%0d required cyc=%0d id=6", done_cyc, done_id_seen, acc_cyc + 2);
        end
    endtask

    task automatic test_wrap();
        clear_log();
        issue(VXOR, EW64, 5'd31, 8'd3, 3'd1);
        wait_done(30);
        checks++;
        if (wb_addr_log.size() !== 3 || wb_addr_log[0] !== 5'd31 || wb_addr_log[1] !== 5'd0 || wb_addr_log[2] !== 5'd1) begin
            errors++;
            $display("FAIL wrap_addr: n=%0d required 3 writes to 31,0,1", wb_addr_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_log();
        issue(VADD, EW64, 5'd20, 8'd4, 3'd4);
        while (wb_addr_log.size() == 0 && n < 20) begin
            cyc();
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || opnd_ready !== 2'b00 || done_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: wb_valid=%b opnd_ready=%b done=%b required 0/00/0", wb_valid, opnd_ready, done_valid);
        end
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        checks++;
        if (insn_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", insn_ready); end
        repeat (8) cyc();
        checks++;
        if (done_cnt !== 0 || wb_addr_log.size() !== 1) begin
            errors++;
            $display("FAIL midrst_quiet: done=%0d writes=%0d required 0/1", done_cnt, wb_addr_log.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        insn_valid = 1'b0;
        insn_op = VADD;
        insn_vew = EW8;
        insn_vd = '0;
        insn_words = '0;
        insn_id = '0;
        opnd_valid = 2'b00;
        opnd_data[0] = '0;
        opnd_data[1] = '0;
        wb_ready = 1'b0;
        clear_log();
        test_reset();
        test_vadd();
        test_vsub();
        test_vmerge();
        test_back_to_back_stall();
        test_zero_words();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
